plights_wb_slave: RTL
=====================

// Module: plights_wb_slave
// PURPOSE
//  Wishbone classic responder serving reads/writes from the plights bus initiator.
//  Holds a small register file and runs a pedestrian-crossing light controller.
//  Car/pedestrian lamp timing comes from registers; crossings are requested by button or register.
//  lights_o drives the board LEDs.
// PARAMETERS
//  BASE_ADDR   32'h91000000  window base; a hit is (wb_adr_i & ADDR_MASK) == BASE_ADDR
//  ADDR_MASK   32'hFFFFFF00  window mask (256-byte window)
//  TIME_W      24            width of timing registers and timer
//  GREEN_DEF   24'd1000      reset value of GREEN_T
//  YELLOW_DEF  24'd200       reset value of YELLOW_T
//  WALK_DEF    24'd800       reset value of WALK_T
// PORTS
//  wb_clk    in   1       clock
//  wb_rst    in   1       synchronous reset, active high
//  wb_adr_i  in   32      byte address; bits [7:2] select the register
//  wb_dat_i  in   32      write data
//  wb_sel_i  in   4       byte lanes; a write updates only the enabled bytes
//  wb_we_i   in   1       1 = write
//  wb_cyc_i  in   1       cycle valid
//  wb_stb_i  in   1       strobe
//  wb_cti_i  in   3       ignored; every access is classic
//  wb_bte_i  in   2       ignored
//  wb_dat_o  out  32      read data; 0 when wb_ack_o is low
//  wb_ack_o  out  1       access done
//  wb_err_o  out  1       hit on an unmapped offset
//  wb_rty_o  out  1       tied 0
//  btn_i     in   1       asynchronous crossing button
//  lights_o  out  5       {car_r, car_y, car_g, ped_r, ped_g}
// BEHAVIOUR
//  Reset: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, lights_o=0, state OFF, CTRL=0, req=0,
//   timer=0, timing registers = *_DEF.
//  Bus: hit = cyc & stb & window match.
//   wb_ack_o/wb_err_o is registered, 1 cycle after hit; it rises only if no ack/err was high
//   the previous cycle, so each access gives a single-cycle pulse.
//   Offsets 0x00-0x14 give ack; other offsets give err, with no write and read data 0.
//   No match gives no response. Write data is sampled on the cycle ack rises.
//  Register map (all other bits read 0, writes to them are ignored):
//   0x00 CTRL      RW  bit0 EN; bit1 REQ is write-1-to-set req and always reads 0
//   0x04 STATUS    RO  [2:0] state code, [8] req
//   0x08 GREEN_T   RW  [TIME_W-1:0]
//   0x0C YELLOW_T  RW
//   0x10 WALK_T    RW
//   0x14 TIMER     RO  current timer value
//  btn_i: 2-FF synchronizer, then a rising-edge detector.
//   Sets req 3 cycles after the btn_i edge, and only when EN=1.
//  FSM (codes): OFF=0, GREEN=1, YELLOW=2, WALK=3, CLEAR=4.
//  Lamp pattern per state:
//   OFF: 00000   GREEN: 00110   YELLOW: 01010   WALK: 10001   CLEAR: 10010
//  Timer: loaded with T on state entry. Each cycle in the state: if timer > 1 then timer-1.
//   Expired means timer <= 1, so every timed state lasts max(T,1) cycles, and T=0 acts as 1.
//  Transitions:
//   OFF->GREEN: EN=1; loads GREEN_T.
//   GREEN->YELLOW: expired & req; GREEN holds indefinitely without req.
//   YELLOW->WALK: expired; clears req.
//   WALK->CLEAR: expired; CLEAR loads YELLOW_T.
//   CLEAR->GREEN: expired.
//   Any state->OFF: EN=0, next cycle; timer and req are cleared.
//  A req during WALK/CLEAR stays pending and is served on the next GREEN.
//  A req set on the same cycle WALK is entered is cleared.
//  Writes to *_T take effect at the next load; the running timer is unaffected.
//  A same-cycle register write and FSM update are both applied.
//  lights_o is registered and follows the state register.
//  wb_rst mid-access: ack is dropped and the access is abandoned.
// TESTING
//  1. Reset, then read 0x08/0x0C/0x10 -> 1000/200/800; STATUS=0; each ack is 1 cycle one clock after stb.
//  2. Read 0x20 -> wb_err_o pulse, wb_ack_o=0, data 0. Access 0x92000000 -> no ack/err within 10 cycles.
//  3. Write CTRL=1, GREEN_T=4, YELLOW_T=2, WALK_T=3, CTRL=3 -> GREEN lasts >=4 cycles, then
//     YELLOW 2 cycles, WALK 3, CLEAR 2, GREEN; lights 00110->01010->10001->10010->00110.
//  4. EN=1, no req -> stays GREEN for 100 cycles. Pulse btn_i -> STATUS[8]=1 on cycle 3 after the edge, then YELLOW.
//  5. Write sel=4'b0001 of 0x12345678 to GREEN_T -> reads 0x000003 78 (i.e. 0x000378).
//     Write YELLOW_T=0 -> YELLOW lasts 1 cycle.
//  6. Write CTRL=0 during WALK -> OFF next cycle, lights 00000, req=0. Assert wb_rst mid-ack -> outputs at reset values.

Source files
------------

// File: rtl/plights_wb_slave.sv
// rtl/plights_wb_slave.sv - Wishbone classic responder with pedestrian-crossing light controller
//
// Purpose: small register file behind a 256-byte Wishbone window that configures
// and observes a car/pedestrian crossing light sequencer driving the board LEDs.
//
// Ports:
//   wb_clk, wb_rst          clock, synchronous active-high reset
//   wb_adr_i[31:0]          byte address, [7:2] selects the register
//   wb_dat_i[31:0]          write data
//   wb_sel_i[3:0]           byte lanes for writes
//   wb_we_i                 1 = write
//   wb_cyc_i, wb_stb_i      cycle / strobe
//   wb_cti_i, wb_bte_i      ignored, every access is classic
//   wb_dat_o[31:0]          read data, 0 whenever wb_ack_o is low
//   wb_ack_o, wb_err_o      single-cycle response pulses
//   wb_rty_o                always 0
//   btn_i                   asynchronous crossing button
//   lights_o[4:0]           {car_r, car_y, car_g, ped_r, ped_g}
module plights_wb_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h91000000,
  parameter logic [31:0] ADDR_MASK  = 32'hFFFFFF00,
  parameter int          TIME_W     = 24,
  parameter logic [TIME_W-1:0] GREEN_DEF  = TIME_W'(1000),
  parameter logic [TIME_W-1:0] YELLOW_DEF = TIME_W'(200),
  parameter logic [TIME_W-1:0] WALK_DEF   = TIME_W'(800)
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  input  logic        btn_i,
  output logic [4:0]  lights_o
);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_GREEN  = 3'd1,
    S_YELLOW = 3'd2,
    S_WALK   = 3'd3,
    S_CLEAR  = 3'd4
  } state_t;

  state_t            r_state, w_state_next;
  logic [TIME_W-1:0] r_timer, w_timer_next, w_timer_dec;
  logic [TIME_W-1:0] r_green_t, r_yellow_t, r_walk_t;
  logic              r_en, r_req, w_req_next, w_req_set, w_req_clr;
  logic              r_ack, r_err;
  logic [31:0]       r_dat, w_rdata;
  logic              r_btn_s1, r_btn_s2, r_btn_prev;
  logic [4:0]        r_lights, w_lights_next;

  logic              w_hit, w_mapped, w_new, w_wr, w_wr_ctrl, w_btn_rise, w_expired;
  logic [5:0]        w_idx;
  logic              w_unused;

  assign w_unused = ^{wb_cti_i, wb_bte_i};

  assign w_hit      = wb_cyc_i & wb_stb_i & ((wb_adr_i & ADDR_MASK) == BASE_ADDR);
  assign w_idx      = wb_adr_i[7:2];
  assign w_mapped   = (w_idx <= 6'd5);
  // A hit only starts a new access if no response was issued last cycle,
  // so a strobe held across the ack cycle does not produce a second pulse.
  assign w_new      = w_hit & ~(r_ack | r_err);
  assign w_wr       = w_new & w_mapped & wb_we_i;
  assign w_wr_ctrl  = w_wr & (w_idx == 6'd0) & wb_sel_i[0];
  assign w_btn_rise = r_btn_s2 & ~r_btn_prev;
  assign w_expired  = (r_timer <= TIME_W'(1));
  assign w_timer_dec = (r_timer > TIME_W'(1)) ? r_timer - TIME_W'(1) : r_timer;

  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;
  assign wb_dat_o = r_dat;
  assign wb_rty_o = 1'b0;
  assign lights_o = r_lights;

  function automatic logic [TIME_W-1:0] f_merge(input logic [TIME_W-1:0] old_v,
                                                input logic [31:0] data,
                                                input logic [3:0] sel);
    logic [31:0] v;
    v = 32'(old_v);
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) v[8*b +: 8] = data[8*b +: 8];
    end
    return v[TIME_W-1:0];
  endfunction

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      6'd0:    w_rdata = {31'b0, r_en};
      6'd1:    w_rdata = {23'b0, r_req, 5'b0, r_state};
      6'd2:    w_rdata = 32'(r_green_t);
      6'd3:    w_rdata = 32'(r_yellow_t);
      6'd4:    w_rdata = 32'(r_walk_t);
      6'd5:    w_rdata = 32'(r_timer);
      default: w_rdata = '0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_req_clr    = 1'b0;
    w_req_set    = (w_wr_ctrl & wb_dat_i[1]) | (w_btn_rise & r_en);
    if (!r_en) begin
      w_state_next = S_OFF;
      w_timer_next = '0;
      w_req_clr    = 1'b1;
    end else begin
      case (r_state)
        S_OFF: begin
          w_state_next = S_GREEN;
          w_timer_next = r_green_t;
        end
        S_GREEN: begin
          if (w_expired && r_req) begin
            w_state_next = S_YELLOW;
            w_timer_next = r_yellow_t;
          end else begin
            w_timer_next = w_timer_dec;
          end
        end
        S_YELLOW: begin
          if (w_expired) begin
            w_state_next = S_WALK;
            w_timer_next = r_walk_t;
            // The crossing is being served; a request arriving now is absorbed.
            w_req_clr    = 1'b1;
          end else begin
            w_timer_next = w_timer_dec;
          end
        end
        S_WALK: begin
          if (w_expired) begin
            w_state_next = S_CLEAR;
            w_timer_next = r_yellow_t;
          end else begin
            w_timer_next = w_timer_dec;
          end
        end
        S_CLEAR: begin
          if (w_expired) begin
            w_state_next = S_GREEN;
            w_timer_next = r_green_t;
          end else begin
            w_timer_next = w_timer_dec;
          end
        end
        default: begin
          w_state_next = S_OFF;
          w_timer_next = '0;
        end
      endcase
    end
    w_req_next = w_req_clr ? 1'b0 : (r_req | w_req_set);
  end

  always_comb begin
    w_lights_next = 5'b00000;
    case (w_state_next)
      S_GREEN:  w_lights_next = 5'b00110;
      S_YELLOW: w_lights_next = 5'b01010;
      S_WALK:   w_lights_next = 5'b10001;
      S_CLEAR:  w_lights_next = 5'b10010;
      default:  w_lights_next = 5'b00000;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_dat      <= '0;
      r_state    <= S_OFF;
      r_timer    <= '0;
      r_req      <= 1'b0;
      r_en       <= 1'b0;
      r_green_t  <= GREEN_DEF;
      r_yellow_t <= YELLOW_DEF;
      r_walk_t   <= WALK_DEF;
      r_btn_s1   <= 1'b0;
      r_btn_s2   <= 1'b0;
      r_btn_prev <= 1'b0;
      r_lights   <= '0;
    end else begin
      r_ack      <= w_new & w_mapped;
      r_err      <= w_new & ~w_mapped;
      r_dat      <= (w_new & w_mapped) ? w_rdata : '0;
      r_btn_s1   <= btn_i;
      r_btn_s2   <= r_btn_s1;
      r_btn_prev <= r_btn_s2;
      r_state    <= w_state_next;
      r_timer    <= w_timer_next;
      r_req      <= w_req_next;
      r_lights   <= w_lights_next;
      if (w_wr) begin
        case (w_idx)
          6'd0: if (wb_sel_i[0]) r_en <= wb_dat_i[0];
          6'd2: r_green_t  <= f_merge(r_green_t,  wb_dat_i, wb_sel_i);
          6'd3: r_yellow_t <= f_merge(r_yellow_t, wb_dat_i, wb_sel_i);
          6'd4: r_walk_t   <= f_merge(r_walk_t,   wb_dat_i, wb_sel_i);
          default: ;
        endcase
      end
    end
  end

endmodule
